// File: rtl/weight_fetch_sequencer_if.sv
// Bundle of command, weight-buffer port-0 and row-stream
// signals used by weight_fetch_sequencer.
interface weight_fetch_sequencer_if #(
    parameter int MATRIX_WIDTH = 14,
    parameter int BYTE_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 15
);
    localparam int DW = MATRIX_WIDTH * BYTE_WIDTH;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_base_addr;
    logic [ADDR_WIDTH:0]   cmd_rows;
    logic [ADDR_WIDTH-1:0] buf_address;
    logic                  buf_en;
    logic                  buf_enable;
    logic [DW-1:0]         buf_read_port;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         out_data;
    logic                  out_last;
    logic                  busy;

    modport slave (
        input  cmd_valid, cmd_base_addr, cmd_rows,
        input  buf_read_port, out_ready,
        output cmd_ready, buf_address, buf_en,
        output buf_enable, out_valid, out_data,
        output out_last, busy
    );

    modport master (
        output cmd_valid, cmd_base_addr, cmd_rows,
        output buf_read_port, out_ready,
        input  cmd_ready, buf_address, buf_en,
        input  buf_enable, out_valid, out_data,
        input  out_last, busy
    );
endinterface

// File: rtl/weight_fetch_sequencer.sv
// Issues sequential weight-buffer reads for a (base, rows)
// command and streams the returned rows through a credit FIFO.
module weight_fetch_sequencer #(
    parameter int MATRIX_WIDTH = 14,
    parameter int BYTE_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 15,
    parameter int READ_LATENCY = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input logic clk,
    input logic rst,
    weight_fetch_sequencer_if.slave bus
);
    localparam int DW = MATRIX_WIDTH * BYTE_WIDTH;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH:0]     rows_q;
    logic [ADDR_WIDTH:0]     idx_q;
    logic [READ_LATENCY-1:0] vld_sr;
    logic [READ_LATENCY-1:0] last_sr;
    logic [DW-1:0]           mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   mem_last;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           credit;

    logic accept;
    logic issue;
    logic last_issue;
    logic push;
    logic pop;
    logic empty;
    logic credit_ok;
    logic head_last;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign accept     = bus.cmd_valid && bus.cmd_ready;
    assign empty      = (count == '0);
    assign pop        = !empty && bus.out_ready;
    assign push       = vld_sr[READ_LATENCY-1];
    assign head_last  = mem_last[rd_ptr];
    assign last_issue = (idx_q == rows_q - ONE);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++)
            inflight = inflight + CW'(vld_sr[i]);
    end

    // Reads in flight are reserved FIFO slots; a pop frees one now.
    assign credit    = count + inflight - CW'(pop);
    assign credit_ok = credit < CW'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept && bus.cmd_rows != '0) state_nx = ISSUE;
            ISSUE:   if (issue && last_issue) state_nx = DRAIN;
            DRAIN:   if (pop && head_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b0;
        issue         = 1'b0;
        unique case (state)
            IDLE:  bus.cmd_ready = rst;
            ISSUE: begin
                bus.busy = 1'b1;
                issue    = credit_ok;
            end
            DRAIN: bus.busy = 1'b1;
            default: ;
        endcase
    end

    assign bus.buf_en      = issue;
    assign bus.buf_address = issue ? base_q + idx_q[ADDR_WIDTH-1:0] : '0;
    assign bus.buf_enable  = rst;
    assign bus.out_valid   = !empty;
    assign bus.out_data    = empty ? '0 : mem[rd_ptr];
    assign bus.out_last    = !empty && head_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q <= '0;
            rows_q <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            base_q <= bus.cmd_base_addr;
            rows_q <= bus.cmd_rows;
            idx_q  <= '0;
        end else if (issue) begin
            idx_q <= idx_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr[0]  <= issue;
            last_sr[0] <= issue && last_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            mem_last <= '0;
        end else begin
            if (push) begin
                mem_last[wr_ptr] <= last_sr[READ_LATENCY-1];
                wr_ptr           <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.buf_read_port;
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst)
        push && !pop |-> count < CW'(FIFO_DEPTH)
    );
endmodule
